// File: rtl/apb_pkg.sv
// Shared definitions for the APB master sequencer: FSM encoding, size codes and
// the peripheral bridge address map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [1:0]  SZ_BYTE         = 2'b00;
  localparam logic [1:0]  SZ_HALF         = 2'b01;
  localparam logic [1:0]  SZ_WORD         = 2'b10;

  localparam logic [15:0] APB_BRIDGE_BASE = 16'h2000;
  localparam logic [3:0]  APB_UART_OFFSET = 4'h0;

  // Upper half-word selects the bridge; the lower half is the peripheral offset.
  function automatic logic in_bridge(input logic [31:0] addr, input logic [15:0] base);
    return addr[31:16] == base;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS-phase wait counter: flags expiry when PREADY has stayed low for
// TIMEOUT_CYCLES consecutive ACCESS cycles.
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic pready_i,
  output logic expired_o
);
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding at zero outside ACCESS gives the clear-on-entry behaviour for free.
  always_comb begin
    cnt_d = '0;
    if (active_i && !pready_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = active_i && !pready_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: turns one CPU load/store into an APB SETUP/ACCESS transfer,
// stalling the pipeline until PREADY. Define APB_TIMEOUT_EN for an ACCESS timeout.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter logic [15:0] BRIDGE_BASE    = APB_BRIDGE_BASE,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_size,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [1:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);
  apb_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic        legal;
  logic        timeout;

  assign legal = in_bridge(cpu_addr, BRIDGE_BASE);

`ifdef APB_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .active_i (state_q == ACCESS),
    .pready_i (PREADY),
    .expired_o(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = legal ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    cpu_done  = (state_q == RESP);
    cpu_err   = (state_q == RESP) && err_q;
    cpu_stall = (state_q == SETUP) || (state_q == ACCESS) || ((state_q == IDLE) && cpu_req);
  end

  // Transfer fields are frozen at acceptance so later CPU-side changes cannot leak onto the bus.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == IDLE && cpu_req) begin
      err_d = !legal;
      if (legal) begin
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        we_d    = cpu_we;
        size_d  = cpu_size;
      end
    end else if (state_q == ACCESS) begin
      if (PREADY) begin
        err_d = 1'b0;
        if (!we_q) rdata_d = PRDATA;
      end else if (timeout) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign PWRITE    = we_q;
  assign PSTRB     = size_q;
  assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl; define APB_TIMEOUT_EN to also exercise
// the ACCESS timeout (bench instantiates TIMEOUT_CYCLES=4).
module tb_apb_master_ctrl;
  localparam int TB_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_size;
  logic        cpu_stall, cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [1:0]  PSTRB;
  logic        PREADY;

  apb_master_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_size(cpu_size), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
    .cpu_err(cpu_err), .cpu_rdata(cpu_rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle phase outputs plus the model's view of latched transfer fields.
  logic        exp_psel = 0, exp_pen = 0, exp_stall = 0, exp_done = 0, exp_err = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic        m_we = 0;
  logic [1:0]  m_size = 0;
  bit          chk_en = 0;

  // Observations recorded for the literal checks.
  int          req_cyc = 0, done_cyc = -100, done_cnt = 0, psel_cnt = 0;
  logic [31:0] done_rdata = 0, setup_paddr = 0;
  logic        done_err = 0, setup_pwrite = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("PSEL", 32'(PSEL), 32'(exp_psel));
      chk("PENABLE", 32'(PENABLE), 32'(exp_pen));
      chk("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
      chk("cpu_done", 32'(cpu_done), 32'(exp_done));
      chk("cpu_err", 32'(cpu_err), 32'(exp_err));
      chk("PADDR", PADDR, m_addr);
      chk("PWDATA", PWDATA, m_wdata);
      chk("PWRITE", 32'(PWRITE), 32'(m_we));
      chk("PSTRB", 32'(PSTRB), 32'(m_size));
      chk("cpu_rdata", cpu_rdata, m_rdata);
      if (cpu_done) begin
        done_cyc   = cyc;
        done_rdata = cpu_rdata;
        done_err   = cpu_err;
        done_cnt++;
      end
      if (PSEL) psel_cnt++;
      if (PSEL && !PENABLE) begin
        setup_paddr  = PADDR;
        setup_pwrite = PWRITE;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic psel, input logic pen, input logic stall,
                         input logic done, input logic err);
    exp_psel = psel; exp_pen = pen; exp_stall = stall; exp_done = done; exp_err = err;
  endtask

  // One CPU transaction. waits = PREADY-low ACCESS cycles before ready; stuck = PREADY
  // never rises (timeout build only). hold_next keeps cpu_req high with a new address.
  task automatic run_xfer(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [1:0] size, input int waits, input logic [31:0] rd,
                          input bit stuck, input bit hold_next, input logic [31:0] next_addr);
    logic legal, err;
    legal = (addr[31:16] == 16'h2000);
    cpu_req = 1; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata; cpu_size = size;
    PREADY = (waits == 0 && !stuck); PRDATA = rd;
    set_exp(0, 0, 1, 0, 0);
    req_cyc = cyc;
    tick();
    cpu_req = hold_next;
    if (hold_next) begin
      cpu_addr = next_addr; cpu_wdata = ~wdata;
    end
    if (legal) begin
      m_addr = addr; m_wdata = wdata; m_we = we; m_size = size;
      set_exp(1, 0, 1, 0, 0);
      tick();
      if (stuck) begin
        PREADY = 0;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
          set_exp(1, 1, 1, 0, 0);
          tick();
        end
        err = 1;
      end else begin
        for (int i = 0; i <= waits; i++) begin
          PREADY = (i == waits);
          set_exp(1, 1, 1, 0, 0);
          tick();
        end
        if (!we) m_rdata = rd;
        err = 0;
      end
    end else begin
      err = 1;
    end
    PREADY = (waits == 0 && !stuck);
    set_exp(0, 0, 0, 1, err);
    tick();
    if (!hold_next) begin
      cpu_req = 0;
      set_exp(0, 0, 0, 0, 0);
    end
  endtask

  task automatic idle(input int n);
    cpu_req = 0;
    set_exp(0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int psel_before, done_before;
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 0;
    PRDATA = 0; PREADY = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    idle(2);

    // Store, zero wait states, PREADY tied high
    run_xfer(32'h2000_0004, 1, 32'hDEAD_BEEF, 2'b10, 0, 32'h0, 0, 0, 0);
    chk("store_latency", 32'(done_cyc - req_cyc), 32'd3);
    chk("store_err", 32'(done_err), 32'd0);
    chk("store_setup_paddr", setup_paddr, 32'h2000_0004);
    chk("store_setup_pwrite", 32'(setup_pwrite), 32'd1);
    idle(2);

    // Load, 3 wait states
    run_xfer(32'h2000_0000, 0, 32'h0, 2'b00, 3, 32'h0000_0041, 0, 0, 0);
    chk("load_latency", 32'(done_cyc - req_cyc), 32'd6);
    chk("load_rdata", done_rdata, 32'h0000_0041);
    chk("load_err", 32'(done_err), 32'd0);
    idle(2);

`ifdef APB_TIMEOUT_EN
    // PREADY stuck low: timeout after TB_TIMEOUT ACCESS cycles, rdata kept
    run_xfer(32'h2000_0010, 0, 32'h0, 2'b10, 0, 32'hBAD0_BAD0, 1, 0, 0);
    chk("timeout_latency", 32'(done_cyc - req_cyc), 32'd6);
    chk("timeout_err", 32'(done_err), 32'd1);
    chk("timeout_rdata", done_rdata, 32'h0000_0041);
    idle(2);
`endif

    // Decode error: no bus activity
    psel_before = psel_cnt;
    run_xfer(32'h1000_0000, 1, 32'h1234_5678, 2'b10, 0, 32'h0, 0, 0, 0);
    chk("decode_latency", 32'(done_cyc - req_cyc), 32'd1);
    chk("decode_err", 32'(done_err), 32'd1);
    chk("decode_no_psel", 32'(psel_cnt - psel_before), 32'd0);
    idle(1);

    // Back-to-back: request held high through the first transfer
    run_xfer(32'h2000_0020, 0, 32'h0, 2'b01, 1, 32'hCAFE_0001, 0, 1, 32'h2000_0030);
    chk("b2b_first_rdata", done_rdata, 32'hCAFE_0001);
    run_xfer(32'h2000_0030, 1, 32'h5555_AAAA, 2'b11, 0, 32'h0, 0, 0, 0);
    chk("b2b_second_paddr", setup_paddr, 32'h2000_0030);
    chk("b2b_second_latency", 32'(done_cyc - req_cyc), 32'd3);
    idle(2);

    // Reset held 2 cycles mid-ACCESS: bus drops, no done pulse ever
    done_before = done_cnt;
    cpu_req = 1; cpu_addr = 32'h2000_0008; cpu_we = 0; cpu_wdata = 0; cpu_size = 2'b10;
    PREADY = 0; PRDATA = 32'h7777_7777;
    set_exp(0, 0, 1, 0, 0);
    tick();
    cpu_req = 0;
    m_addr = 32'h2000_0008; m_wdata = 0; m_we = 0; m_size = 2'b10;
    set_exp(1, 0, 1, 0, 0);
    tick();
    set_exp(1, 1, 1, 0, 0);
    tick();
    rst = 1;
    tick();
    m_addr = 0; m_wdata = 0; m_we = 0; m_size = 0; m_rdata = 0;
    set_exp(0, 0, 0, 0, 0);
    tick();
    rst = 0;
    PREADY = 1;
    idle(4);
    chk("reset_no_done", 32'(done_cnt - done_before), 32'd0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
